// File: rtl/icache_controller.sv
// icache_controller
//   Control FSM for a direct-mapped instruction cache. Accepts one CPU fetch
//   at a time, looks it up in the registered cache storage, and on a miss
//   refills the whole line from memory word by word before writing it back
//   with a single strobe and answering the CPU from the fill buffer.
//
// Ports
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   cpu_req/cpu_addr     : fetch request and word address
//   cpu_ready            : request accepted this cycle (IDLE only)
//   cpu_valid/cpu_data   : one-cycle response strobe and fetched word
//   cache_read/write     : lookup strobe / line-write strobe to storage
//   cache_addr           : latched request address during LOOKUP and FILL
//   cache_write_block    : fill buffer, word i at [i*WORD_WIDTH +: WORD_WIDTH]
//   cache_hit/read_data  : registered lookup result from storage
//   mem_rd/mem_addr      : memory word read request and address
//   mem_rvalid/mem_rdata : memory response for the current mem_addr
//   hit_count/miss_count : saturating performance counters
module icache_controller #(
  parameter int BLOCK_SIZE = 4,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpu_req,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  output logic                             cpu_ready,
  output logic                             cpu_valid,
  output logic [WORD_WIDTH-1:0]            cpu_data,
  output logic                             cache_read,
  output logic                             cache_write,
  output logic [ADDR_WIDTH-1:0]            cache_addr,
  output logic [WORD_WIDTH*BLOCK_SIZE-1:0] cache_write_block,
  input  logic                             cache_hit,
  input  logic [WORD_WIDTH-1:0]            cache_read_data,
  output logic                             mem_rd,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic                             mem_rvalid,
  input  logic [WORD_WIDTH-1:0]            mem_rdata,
  output logic [CNT_WIDTH-1:0]             hit_count,
  output logic [CNT_WIDTH-1:0]             miss_count
);

  localparam int OFF_W  = $clog2(BLOCK_SIZE);
  localparam int LINE_W = WORD_WIDTH * BLOCK_SIZE;

  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, REFILL, FILL} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [OFF_W-1:0]      wcnt_q, wcnt_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [CNT_WIDTH-1:0]  hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0]  miss_count_q, miss_count_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      wcnt_q       <= '0;
      line_q       <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      wcnt_q       <= wcnt_d;
      line_q       <= line_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Next state and datapath updates
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    wcnt_d       = wcnt_q;
    line_d       = line_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          req_addr_d = cpu_addr;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: state_d = CHECK;
      CHECK: begin
        if (cache_hit) begin
          hit_count_d = sat_inc(hit_count_q);
          state_d     = IDLE;
        end else begin
          miss_count_d = sat_inc(miss_count_q);
          wcnt_d       = '0;
          state_d      = REFILL;
        end
      end
      REFILL: begin
        // Only responses arriving here land in the buffer; wcnt wraps to 0
        // on the last word so it is clean for the next refill.
        if (mem_rvalid) begin
          line_d[wcnt_q*WORD_WIDTH +: WORD_WIDTH] = mem_rdata;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == OFF_W'(BLOCK_SIZE - 1)) state_d = FILL;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cpu_ready         = 1'b0;
    cpu_valid         = 1'b0;
    cpu_data          = '0;
    cache_read        = 1'b0;
    cache_write       = 1'b0;
    cache_addr        = '0;
    mem_rd            = 1'b0;
    mem_addr          = '0;
    cache_write_block = line_q;
    hit_count         = hit_count_q;
    miss_count        = miss_count_q;
    case (state_q)
      IDLE:   cpu_ready = 1'b1;
      LOOKUP: begin
        cache_read = 1'b1;
        cache_addr = req_addr_q;
      end
      CHECK: begin
        if (cache_hit) begin
          cpu_valid = 1'b1;
          cpu_data  = cache_read_data;
        end
      end
      REFILL: begin
        mem_rd   = 1'b1;
        mem_addr = {req_addr_q[ADDR_WIDTH-1:OFF_W], wcnt_q};
      end
      FILL: begin
        cache_write = 1'b1;
        cache_addr  = req_addr_q;
        cpu_valid   = 1'b1;
        cpu_data    = line_q[req_addr_q[OFF_W-1:0]*WORD_WIDTH +: WORD_WIDTH];
      end
      default: ;
    endcase
    // A reset cycle must never hand out a response, a write or a grant, even
    // if it lands while the FSM is still sitting in FILL or CHECK.
    if (reset) begin
      cpu_ready   = 1'b0;
      cpu_valid   = 1'b0;
      cache_read  = 1'b0;
      cache_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
// tb_icache_controller
//   Drives icache_controller with directed and randomized fetches against a
//   direct-mapped storage model and a word-addressed memory model, and checks
//   responses, latencies, refill traffic and counters against a reference
//   that only knows which line is resident at each index.
module tb_icache_controller;

  localparam int BS = 4;
  localparam int WW = 32;
  localparam int AW = 32;
  localparam int NL = 16;
  localparam int LW = WW * BS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_ready, cpu_valid;
  logic [WW-1:0] cpu_data;
  logic          cache_read, cache_write;
  logic [AW-1:0] cache_addr;
  logic [LW-1:0] cache_write_block;
  logic          cache_hit = 1'b0;
  logic [WW-1:0] cache_read_data = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_rvalid = 1'b0;
  logic [WW-1:0] mem_rdata = '0;
  logic [31:0]   hit_count, miss_count;

  logic          s_cpu_ready, s_cpu_valid, s_cache_read, s_cache_write, s_mem_rd;
  logic [WW-1:0] s_cpu_data;
  logic [AW-1:0] s_cache_addr, s_mem_addr;
  logic [LW-1:0] s_cache_write_block;
  logic [3:0]    s_hit_count, s_miss_count;

  always #5 clk = ~clk;

  icache_controller #(.BLOCK_SIZE(BS), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_data(cpu_data),
    .cache_read(cache_read), .cache_write(cache_write), .cache_addr(cache_addr),
    .cache_write_block(cache_write_block), .cache_hit(cache_hit),
    .cache_read_data(cache_read_data), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Narrow-counter twin running in lockstep on the same inputs
  icache_controller #(.BLOCK_SIZE(BS), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(s_cpu_ready), .cpu_valid(s_cpu_valid), .cpu_data(s_cpu_data),
    .cache_read(s_cache_read), .cache_write(s_cache_write), .cache_addr(s_cache_addr),
    .cache_write_block(s_cache_write_block), .cache_hit(cache_hit),
    .cache_read_data(cache_read_data), .mem_rd(s_mem_rd), .mem_addr(s_mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  // Storage: 16 lines, index = addr[5:2], tag = addr[31:6], registered read
  logic [LW-1:0] st_line [NL];
  logic [AW-1:0] st_tag  [NL];
  logic          st_v    [NL] = '{default: 1'b0};

  always @(posedge clk) begin
    if (cache_read) begin
      cache_hit       <= st_v[cache_addr[5:2]] && (st_tag[cache_addr[5:2]] == (cache_addr >> 6));
      cache_read_data <= st_line[cache_addr[5:2]][cache_addr[1:0]*WW +: WW];
    end
    if (cache_write) begin
      st_v[cache_addr[5:2]]    <= 1'b1;
      st_tag[cache_addr[5:2]]  <= cache_addr >> 6;
      st_line[cache_addr[5:2]] <= cache_write_block;
    end
  end

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    return a + 32'h60;
  endfunction

  // Reference: which tag is resident per index, counters, last filled line
  logic          res_v   [NL] = '{default: 1'b0};
  logic [AW-1:0] res_tag [NL];
  int unsigned   m_hits, m_miss;
  logic [LW-1:0] m_buf;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle bookkeeping filled in by step()
  int            cyc = 0;
  int            gap = 0, gap_cnt = 0;
  bit            stray = 0;
  logic [AW-1:0] rv_q [$];
  int            last_rv, cw_n, cw_cyc, vn, v_cyc;
  logic [LW-1:0] cw_blk;
  logic [AW-1:0] cw_addr;
  logic [WW-1:0] v_data;
  bit            rd_seen, rdy_busy;

  // Advance to the next negedge, record what the DUT shows, then drive memory
  task automatic step();
    @(negedge clk);
    cyc++;
    if (mem_rd) rd_seen = 1;
    if (cache_write) begin
      cw_n++; cw_cyc = cyc; cw_blk = cache_write_block; cw_addr = cache_addr;
    end
    if (cpu_valid) begin
      vn++; v_cyc = cyc; v_data = cpu_data;
    end
    if (stray) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD00000 ^ WW'($urandom_range(0, 65535));
      stray      = 0;
      gap_cnt    = gap;
    end else if (mem_rd) begin
      if (gap_cnt >= gap) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(mem_addr);
        rv_q.push_back(mem_addr);
        last_rv    = cyc;
        gap_cnt    = 0;
      end else begin
        mem_rvalid = 1'b0;
        gap_cnt++;
      end
    end else begin
      mem_rvalid = 1'b0;
      gap_cnt    = gap;
    end
  endtask

  task automatic clear_marks(input int g);
    gap = g; gap_cnt = g; rv_q.delete();
    rd_seen = 0; rdy_busy = 0; cw_n = 0; vn = 0;
  endtask

  task automatic chk_counters();
    chk_eq("hit_cnt", hit_count, m_hits);
    chk_eq("miss_cnt", miss_count, m_miss);
    chk_eq("sat_hit_cnt", s_hit_count, (m_hits > 15) ? 15 : m_hits);
    chk_eq("sat_miss_cnt", s_miss_count, (m_miss > 15) ? 15 : m_miss);
  endtask

  // Start in the current (IDLE) cycle; return in the IDLE cycle after cpu_valid
  task automatic fetch(input logic [AW-1:0] a, input int g);
    logic [3:0]    idx;
    logic [AW-1:0] tag, base;
    logic [LW-1:0] line;
    bit            exp_hit;
    int            c0, t;
    idx     = a[5:2];
    tag     = a >> 6;
    base    = {a[AW-1:2], 2'b00};
    exp_hit = res_v[idx] && (res_tag[idx] == tag);
    for (int k = 0; k < BS; k++) line[k*WW +: WW] = mem_word(base + AW'(k));
    clear_marks(g);
    chk_eq("accept_ready", cpu_ready, 1);
    cpu_req = 1'b1; cpu_addr = a; c0 = cyc;
    step();
    cpu_req = 1'b0; cpu_addr = $urandom;
    chk_eq("lookup_read", cache_read, 1);
    chk_eq("lookup_addr", cache_addr, a);
    t = 0;
    while (vn == 0 && t < 200) begin
      step();
      if (cpu_ready) rdy_busy = 1;
      cpu_req = 1'($urandom_range(0, 1));
      t++;
    end
    cpu_req = 1'b0;
    chk_eq("valid_once", vn, 1);
    chk_eq("busy_not_ready", rdy_busy, 0);
    chk_eq("data", v_data, mem_word(a));
    if (exp_hit) begin
      chk_eq("hit_latency", v_cyc - c0, 2);
      chk_eq("hit_no_mem", rd_seen, 0);
      chk_eq("hit_no_write", cw_n, 0);
      m_hits++;
    end else begin
      chk_eq("miss_words", rv_q.size(), BS);
      for (int k = 0; k < rv_q.size(); k++) chk_eq("miss_mem_addr", rv_q[k], base + AW'(k));
      chk_eq("fill_after_last", v_cyc, last_rv + 1);
      if (g == 0) chk_eq("miss_latency", v_cyc - c0, 3 + BS);
      chk_eq("write_once", cw_n, 1);
      chk_eq("write_cycle", cw_cyc, v_cyc);
      chk_eq("write_block", cw_blk, line);
      chk_eq("write_addr", cw_addr, a);
      m_miss++;
      res_v[idx] = 1'b1; res_tag[idx] = tag; m_buf = line;
    end
    step();
    chk_eq("idle_ready", cpu_ready, 1);
    chk_eq("idle_quiet", {cpu_valid, cache_read, cache_write, mem_rd}, 0);
    chk_counters();
  endtask

  task automatic chk_quiet_outputs(input string tag);
    chk_eq(tag, {cpu_valid, cache_read, cache_write, mem_rd, mem_addr, cache_addr, cpu_data}, 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      step();
      chk_eq("rst_ready_low", cpu_ready, 0);
      chk_quiet_outputs("rst_outputs");
    end
    reset = 1'b0;
    #1;
    m_hits = 0; m_miss = 0; m_buf = '0;
    chk_eq("rel_ready", cpu_ready, 1);
    chk_quiet_outputs("rel_outputs");
    chk_eq("rel_block", cache_write_block, 0);
    chk_counters();
  endtask

  task automatic reset_mid_refill(input logic [AW-1:0] a);
    int t;
    clear_marks(0);
    cpu_req = 1'b1; cpu_addr = a;
    step();
    cpu_req = 1'b0;
    t = 0;
    while (rv_q.size() < 2 && t < 50) begin step(); t++; end
    chk_eq("mid_two_words", rv_q.size(), 2);
    reset = 1'b1;
    step();
    chk_eq("mid_rd_drop", mem_rd, 0);
    stray = 1;
    step();
    chk_eq("mid_rd_low", mem_rd, 0);
    reset = 1'b0;
    #1;
    m_hits = 0; m_miss = 0; m_buf = '0;
    stray = 1;
    repeat (3) step();
    chk_eq("mid_no_write", cw_n, 0);
    chk_eq("mid_no_valid", vn, 0);
    chk_eq("mid_block_clear", cache_write_block, 0);
    chk_counters();
  endtask

  initial begin
    logic [AW-1:0] a;
    int unsigned   m0;
    do_reset(3);

    fetch(32'h40, 0);
    chk_eq("cold_word", v_data, 32'hA0);
    chk_eq("cold_block", cw_blk, 128'h000000A3_000000A2_000000A1_000000A0);
    fetch(32'h42, 0);
    chk_eq("hit_word", v_data, 32'hA2);

    stray = 1;
    step();
    step();
    chk_eq("stray_block", cache_write_block, m_buf);
    stray = 1;
    step();
    fetch(32'h13, 2);

    reset_mid_refill(32'h80);
    fetch(32'h80, 0);
    chk_eq("refetch_missed", miss_count, 1);

    fetch(32'h440, 0);
    m0 = m_miss;
    fetch(32'h40, 0);
    fetch(32'h440, 0);
    fetch(32'h40, 0);
    chk_eq("conflict_misses", miss_count, m0 + 3);

    for (int i = 0; i < 17; i++) fetch(32'h40 + AW'(i % 4), 0);
    chk_eq("sat_hold", s_hit_count, 4'hF);

    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(0, 2)) * 64 + AW'($urandom_range(0, 3)) * 4 + AW'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin stray = 1; step(); end
      repeat ($urandom_range(0, 2)) step();
      fetch(a, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
